// File: rtl/alu_pkg.sv
// Shared definitions for the decode-to-execute boundary: ALU opcode
// encodings and the layout of the ID/EX pipeline register.
package alu_pkg;

  // Default datapath and register-index widths. id_ex_t is sized by these,
  // so the stage's N and RA_W parameters must keep these values.
  localparam int ID_N    = 32;
  localparam int ID_RA_W = 4;

  // ALU opcode encodings.
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_MOD = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_CAT = 4'd5;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SLL = 4'd9;
  localparam logic [3:0] OP_NOP = OP_ADD;

  // Everything the EX stage remembers about one decoded instruction.
  typedef struct packed {
    logic                 valid;
    logic [3:0]           opcode;
    logic [ID_RA_W-1:0]   rs1;
    logic [ID_RA_W-1:0]   rs2;
    logic [ID_N-1:0]      rs1_data;
    logic [ID_N-1:0]      rs2_data;
    logic [ID_N-1:0]      imm;
    logic                 use_imm;
    logic [ID_RA_W-1:0]   rd;
    logic                 we;
    logic                 mem_read;
  } id_ex_t;

  // Turn an EX entry into a bubble. Operand fields are kept; they are
  // harmless once valid, we and mem_read are low.
  function automatic id_ex_t make_bubble(input id_ex_t e);
    id_ex_t b;
    b          = e;
    b.valid    = 1'b0;
    b.we       = 1'b0;
    b.mem_read = 1'b0;
    b.opcode   = OP_NOP;
    return b;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB,
// which beats the register-file read data. Register 0 is always zero.
module fwd_unit #(
  parameter int N    = 32,
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] rs_i,
  input  logic [N-1:0]    regdata_i,
  input  logic            exmem_we_i,
  input  logic [RA_W-1:0] exmem_rd_i,
  input  logic [N-1:0]    exmem_result_i,
  input  logic            memwb_we_i,
  input  logic [RA_W-1:0] memwb_rd_i,
  input  logic [N-1:0]    memwb_data_i,
  output logic [N-1:0]    val_o
);

  // Select the youngest producer of rs; r0 short-circuits to zero.
  always_comb begin
    // NOTE: assign a default first so every path drives val_o and no latch is inferred.
    val_o = regdata_i;
    if (rs_i == '0) begin
      val_o = '0;
    end else if (exmem_we_i && exmem_rd_i == rs_i) begin
      val_o = exmem_result_i;
    end else if (memwb_we_i && memwb_rd_i == rs_i) begin
      val_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Handles operand forwarding,
// load-use bubbles, external stall/flush and bring-up issue/bubble counters.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int N     = ID_N,
  parameter int RA_W  = ID_RA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [3:0]       dec_opcode,
  input  logic [RA_W-1:0]  dec_rs1,
  input  logic [RA_W-1:0]  dec_rs2,
  input  logic [N-1:0]     dec_rs1_data,
  input  logic [N-1:0]     dec_rs2_data,
  input  logic [N-1:0]     dec_imm,
  input  logic             dec_use_imm,
  input  logic [RA_W-1:0]  dec_rd,
  input  logic             dec_we,
  input  logic             dec_mem_read,
  input  logic             stall,
  input  logic             flush,
  input  logic             exmem_we,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [N-1:0]     exmem_result,
  input  logic             memwb_we,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [N-1:0]     memwb_data,
  output logic             ex_valid,
  output logic [3:0]       alu_opcode,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_we,
  output logic             ex_mem_read,
  output logic [N-1:0]     ex_store_data,
  output logic [CNT_W-1:0] issue_count,
  output logic [CNT_W-1:0] bubble_count
);

  id_ex_t            ex_q, ex_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic              load_use;
  logic [N-1:0]      fwd_rs1, fwd_rs2;

  // A load in EX whose destination is read by the instruction in decode.
  // rs2 only matters when operand B is not the immediate.
  always_comb begin
    load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && dec_valid &&
               ((ex_q.rd == dec_rs1) || ((ex_q.rd == dec_rs2) && !dec_use_imm));
  end

  assign dec_ready = !(stall || load_use);

  // Next-state selection: flush > stall > load-use bubble > load.
  always_comb begin
    ex_d     = ex_q;
    issue_d  = issue_q;
    bubble_d = bubble_q;
    if (flush) begin
      ex_d     = make_bubble(ex_q);
      bubble_d = bubble_q + 1'b1;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d     = make_bubble(ex_q);
      bubble_d = bubble_q + 1'b1;
    end else begin
      ex_d.valid    = dec_valid;
      ex_d.opcode   = dec_opcode;
      ex_d.rs1      = dec_rs1;
      ex_d.rs2      = dec_rs2;
      ex_d.rs1_data = dec_rs1_data;
      ex_d.rs2_data = dec_rs2_data;
      ex_d.imm      = dec_imm;
      ex_d.use_imm  = dec_use_imm;
      ex_d.rd       = dec_rd;
      ex_d.we       = dec_we && dec_valid;
      ex_d.mem_read = dec_mem_read && dec_valid;
      if (dec_valid) begin
        issue_d = issue_q + 1'b1;
      end
    end
  end

  // Pipeline register and counters with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      ex_q     <= '0;
      issue_q  <= '0;
      bubble_q <= '0;
    end else begin
      ex_q     <= ex_d;
      issue_q  <= issue_d;
      bubble_q <= bubble_d;
    end
  end

  fwd_unit #(.N(N), .RA_W(RA_W)) u_fwd_rs1 (
    .rs_i           (ex_q.rs1),
    .regdata_i      (ex_q.rs1_data),
    .exmem_we_i     (exmem_we),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_we_i     (memwb_we),
    .memwb_rd_i     (memwb_rd),
    .memwb_data_i   (memwb_data),
    .val_o          (fwd_rs1)
  );

  fwd_unit #(.N(N), .RA_W(RA_W)) u_fwd_rs2 (
    .rs_i           (ex_q.rs2),
    .regdata_i      (ex_q.rs2_data),
    .exmem_we_i     (exmem_we),
    .exmem_rd_i     (exmem_rd),
    .exmem_result_i (exmem_result),
    .memwb_we_i     (memwb_we),
    .memwb_rd_i     (memwb_rd),
    .memwb_data_i   (memwb_data),
    .val_o          (fwd_rs2)
  );

  assign ex_valid      = ex_q.valid;
  assign alu_opcode    = ex_q.opcode;
  assign alu_a         = fwd_rs1;
  assign alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_we         = ex_q.we;
  assign ex_mem_read   = ex_q.mem_read;
  assign issue_count   = issue_q;
  assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use,
// stall/flush interaction and mid-stream reset.
module tb_id_ex_stage;
  import alu_pkg::*;

  localparam int N     = 32;
  localparam int RA_W  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             dec_valid, dec_ready;
  logic [3:0]       dec_opcode;
  logic [RA_W-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic [N-1:0]     dec_rs1_data, dec_rs2_data, dec_imm;
  logic             dec_use_imm, dec_we, dec_mem_read;
  logic             stall, flush;
  logic             exmem_we, memwb_we;
  logic [RA_W-1:0]  exmem_rd, memwb_rd;
  logic [N-1:0]     exmem_result, memwb_data;
  logic             ex_valid, ex_we, ex_mem_read;
  logic [3:0]       alu_opcode;
  logic [N-1:0]     alu_a, alu_b, ex_store_data;
  logic [RA_W-1:0]  ex_rd;
  logic [CNT_W-1:0] issue_count, bubble_count;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.N(N), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_imm(dec_imm), .dec_use_imm(dec_use_imm), .dec_rd(dec_rd),
    .dec_we(dec_we), .dec_mem_read(dec_mem_read),
    .stall(stall), .flush(flush),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .ex_rd(ex_rd), .ex_we(ex_we), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data),
    .issue_count(issue_count), .bubble_count(bubble_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] op,
                         input logic [RA_W-1:0] rs1, input logic [N-1:0] d1,
                         input logic [RA_W-1:0] rs2, input logic [N-1:0] d2,
                         input logic ui, input logic [N-1:0] imm,
                         input logic [RA_W-1:0] rd, input logic we, input logic mr);
    dec_valid = v;   dec_opcode = op;
    dec_rs1 = rs1;   dec_rs1_data = d1;
    dec_rs2 = rs2;   dec_rs2_data = d2;
    dec_use_imm = ui; dec_imm = imm;
    dec_rd = rd;     dec_we = we;   dec_mem_read = mr;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_we = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
    set_dec(1'b1, OP_SUB, 4'd1, 32'h3, 4'd2, 32'h4, 1'b0, 32'h0, 4'd5, 1'b1, 1'b1);
    tick(); tick();
    rst = 1'b0;
    set_dec(1'b0, OP_ADD, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd0, 1'b0, 1'b0);
    #1;
    // Reset state.
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_we", ex_we, 0);
    check("rst_ex_mem_read", ex_mem_read, 0);
    check("rst_opcode", alu_opcode, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_issue", issue_count, 0);
    check("rst_bubble", bubble_count, 0);
    check("rst_ready", dec_ready, 1);

    // 1: basic issue, one-cycle latency.
    set_dec(1'b1, OP_ADD, 4'd1, 32'd5, 4'd2, 32'd7, 1'b0, 32'h0, 4'd1, 1'b1, 1'b0);
    tick();
    check("t1_valid", ex_valid, 1);
    check("t1_alu_a", alu_a, 5);
    check("t1_alu_b", alu_b, 7);
    check("t1_issue", issue_count, 1);

    // 2: forwarding priority, immediate operand B, store data from rs2=r0.
    set_dec(1'b1, OP_AND, 4'd3, 32'h11, 4'd0, 32'h99, 1'b1, 32'h40, 4'd4, 1'b1, 1'b0);
    tick();
    check("t2_issue", issue_count, 2);
    check("t2_opcode", alu_opcode, 4);
    exmem_we = 1'b1; exmem_rd = 4'd3; exmem_result = 32'hAA;
    memwb_we = 1'b1; memwb_rd = 4'd3; memwb_data = 32'hBB;
    #1;
    check("t2_fwd_exmem", alu_a, 32'hAA);
    check("t2_alu_b_imm", alu_b, 32'h40);
    check("t2_store_r0", ex_store_data, 0);
    exmem_we = 1'b0;
    #1;
    check("t2_fwd_memwb", alu_a, 32'hBB);
    memwb_we = 1'b0;
    #1;
    check("t2_no_fwd", alu_a, 32'h11);
    set_dec(1'b1, OP_ADD, 4'd0, 32'h55, 4'd1, 32'h66, 1'b0, 32'h0, 4'd4, 1'b1, 1'b0);
    tick();
    exmem_we = 1'b1; exmem_rd = 4'd0;
    memwb_we = 1'b1; memwb_rd = 4'd0;
    #1;
    check("t2_r0_zero", alu_a, 0);
    check("t2_rs2_regdata", alu_b, 32'h66);
    exmem_we = 1'b0; memwb_we = 1'b0;

    // 3: load-use on rs2, then no hazard when operand B is the immediate.
    set_dec(1'b1, OP_ADD, 4'd1, 32'h0, 4'd5, 32'h0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b1);
    tick();
    check("t3_load_in_ex", ex_mem_read, 1);
    check("t3_issue_a", issue_count, 4);
    set_dec(1'b1, OP_ADD, 4'd6, 32'h0, 4'd2, 32'h0, 1'b0, 32'h0, 4'd7, 1'b1, 1'b0);
    #1;
    check("t3_hazard_ready", dec_ready, 0);
    tick();
    check("t3_bubble_valid", ex_valid, 0);
    check("t3_bubble_cnt", bubble_count, 1);
    check("t3_issue_held", issue_count, 4);
    set_dec(1'b1, OP_ADD, 4'd1, 32'h0, 4'd3, 32'h0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b1);
    tick();
    check("t3_issue_b", issue_count, 5);
    set_dec(1'b1, OP_ADD, 4'd6, 32'h0, 4'd2, 32'h0, 1'b1, 32'h8, 4'd7, 1'b1, 1'b0);
    #1;
    check("t3_imm_ready", dec_ready, 1);
    tick();
    check("t3_imm_valid", ex_valid, 1);
    check("t3_imm_issue", issue_count, 6);
    check("t3_imm_bubble", bubble_count, 1);
    // A load targeting r0 never creates a hazard.
    set_dec(1'b1, OP_ADD, 4'd1, 32'h0, 4'd3, 32'h0, 1'b0, 32'h0, 4'd0, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, OP_SUB, 4'd0, 32'h9, 4'd0, 32'h3, 1'b0, 32'h0, 4'd8, 1'b1, 1'b0);
    #1;
    check("t3_r0_ready", dec_ready, 1);
    tick();
    check("t3_r0_issue", issue_count, 8);
    check("t3_r0_opcode", alu_opcode, 1);
    check("t3_r0_ex_rd", ex_rd, 8);
    check("t3_r0_ex_we", ex_we, 1);

    // 4: stall and flush together -> bubble, not hold.
    stall = 1'b1; flush = 1'b1;
    #1;
    check("t4_ready", dec_ready, 0);
    tick();
    check("t4_valid", ex_valid, 0);
    check("t4_we", ex_we, 0);
    check("t4_opcode", alu_opcode, 0);
    check("t4_bubble", bubble_count, 2);
    check("t4_issue", issue_count, 8);
    stall = 1'b0; flush = 1'b0;

    // 5: three-cycle stall holds EX.
    set_dec(1'b1, OP_SLL, 4'd1, 32'h1234, 4'd2, 32'h5678, 1'b0, 32'h0, 4'd3, 1'b1, 1'b0);
    tick();
    check("t5_issue", issue_count, 9);
    set_dec(1'b1, OP_MUL, 4'd4, 32'hDEAD, 4'd5, 32'hBEEF, 1'b0, 32'h0, 4'd6, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_ready", dec_ready, 0);
      tick();
      check("t5_opcode", alu_opcode, 9);
      check("t5_alu_a", alu_a, 32'h1234);
      check("t5_alu_b", alu_b, 32'h5678);
      check("t5_issue_held", issue_count, 9);
    end
    stall = 1'b0;

    // 6: reset with a live load in EX and a dependent instruction in decode.
    set_dec(1'b1, OP_ADD, 4'd1, 32'h0, 4'd3, 32'h0, 1'b0, 32'h0, 4'd2, 1'b1, 1'b1);
    tick();
    check("t6_issue", issue_count, 10);
    check("t6_load", ex_mem_read, 1);
    set_dec(1'b1, OP_ADD, 4'd2, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0, 4'd7, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check("t6_valid", ex_valid, 0);
    check("t6_mem_read", ex_mem_read, 0);
    check("t6_ex_we", ex_we, 0);
    check("t6_ex_rd", ex_rd, 0);
    check("t6_opcode", alu_opcode, 0);
    check("t6_issue", issue_count, 0);
    check("t6_bubble", bubble_count, 0);
    check("t6_ready", dec_ready, 1);
    rst = 1'b0;
    dec_valid = 1'b0;
    tick();
    check("t6_idle_issue", issue_count, 0);
    check("t6_idle_valid", ex_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
